// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: load/store controller between the core memory stage and a
// word-wide data RAM that only supports full-word writes.
//   i_req/i_we/i_funct3/i_addr/i_wdata : request, sampled in IDLE only
//   o_busy/o_done/o_err/o_rdata        : status and extended load result
//   o_lsu_addr/o_wren/o_wdata          : RAM word index, write enable, data
//   i_data_dmem                        : RAM combinational read data
// Sub-word stores are a read-modify-write: RD captures the word, WR merges.
module lsu_dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic [31:0] o_lsu_addr,
  output logic        o_wren,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_data_dmem
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_word_q, rd_word_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_err;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Request validation works on the live inputs, as they are latched
  // on the same edge that picks the next state.
  always_comb begin
    req_err = 1'b0;
    if (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111)
      req_err = 1'b1;
    if (i_we && i_funct3[2])
      req_err = 1'b1;
    if (i_funct3[1:0] == 2'b01 && i_addr[0])
      req_err = 1'b1;
    if (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if ({2'b00, i_addr[31:2]} >= DEPTH_WORDS)
      req_err = 1'b1;
  end

  // Load extraction from the live RAM word during RD.
  always_comb begin
    rd_shift = i_data_dmem >> {addr_q[1:0], 3'b000};
    rd_half  = addr_q[1] ? i_data_dmem[31:16] : i_data_dmem[15:0];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{rd_shift[7] & ~funct3_q[2]}}, rd_shift[7:0]};
      2'b01:   load_ext = {{16{rd_half[15] & ~funct3_q[2]}}, rd_half};
      default: load_ext = i_data_dmem;
    endcase
  end

  // Store merge of the latched data into the captured word.
  always_comb begin
    merged = rd_word_q;
    case (funct3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'b00: merged[7:0]   = wdata_q[7:0];
          2'b01: merged[15:8]  = wdata_q[7:0];
          2'b10: merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_word_d = rd_word_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          we_d     = i_we;
          funct3_d = i_funct3;
          addr_d   = i_addr;
          wdata_d  = i_wdata;
          if (req_err)                   state_d = S_ERR;
          else if (!i_we)                state_d = S_RD;
          else if (i_funct3 == 3'b010)   state_d = S_WR;
          else                           state_d = S_RD;
        end
      end
      S_RD: begin
        rd_word_d = i_data_dmem;
        if (we_q) begin
          state_d = S_WR;
        end else begin
          rdata_d = load_ext;
          state_d = S_DONE;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_word_q <= rd_word_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_DONE) || (state_q == S_ERR);
  assign o_err      = (state_q == S_ERR);
  assign o_rdata    = rdata_q;
  assign o_wren     = (state_q == S_WR);
  assign o_lsu_addr = (state_q == S_RD || state_q == S_WR) ? {2'b00, addr_q[31:2]} : '0;
  assign o_wdata    = (state_q == S_WR) ? merged : '0;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err, wren;
  logic [31:0] rdata, lsu_addr, ram_wdata, dmem;

  logic [31:0] mem [1024];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_widx = '0;
  logic [31:0] tb_wval = '0;

  int n_vec = 0;
  int n_fail = 0;
  int wren_cnt = 0;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.DEPTH_WORDS(1024)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_funct3(funct3),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_err(err),
    .o_rdata(rdata), .o_lsu_addr(lsu_addr), .o_wren(wren), .o_wdata(ram_wdata),
    .i_data_dmem(dmem)
  );

  assign dmem = (lsu_addr < 32'd1024) ? mem[lsu_addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (wren && lsu_addr < 32'd1024) mem[lsu_addr[9:0]] <= ram_wdata;
    else if (tb_we) mem[tb_widx] <= tb_wval;
  end

  always @(negedge clk) if (wren) wren_cnt <= wren_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    tb_we = 1'b1; tb_widx = idx[9:0]; tb_wval = val;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          nwr;
    int          midx;
    logic [31:0] mval;
  } vec_t;

  // Issue one request, wait for o_done, check latency/err/rdata/write count.
  task automatic do_req(input string name, input vec_t v);
    int lat;
    int base;
    bit seen;
    @(negedge clk);
    base = wren_cnt;
    req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
    end
    if (!seen) begin
      n_vec++; n_fail++;
      $display("FAIL %s timeout: no done after %0d cycles", name, lat);
    end else begin
      check({name, " lat"}, lat, v.lat);
      check({name, " err"}, {31'b0, err}, {31'b0, v.err});
      check({name, " rdata"}, rdata, v.rdata);
    end
    @(negedge clk);
    check({name, " wren_cnt"}, wren_cnt - base, v.nwr);
    if (v.midx >= 0) check({name, " mem"}, mem[v.midx], v.mval);
  endtask

  vec_t vt [21];

  initial begin
    vt[0]  = '{1'b0, 3'b010, 32'h10,  32'h0,        2, 1'b0, 32'hDEADBEEF, 0, -1, 32'h0};
    vt[1]  = '{1'b1, 3'b010, 32'h10,  32'h11223344, 2, 1'b0, 32'hDEADBEEF, 1, 4, 32'h11223344};
    vt[2]  = '{1'b1, 3'b000, 32'h13,  32'hFFFFFFA5, 3, 1'b0, 32'hDEADBEEF, 1, 4, 32'hA5223344};
    vt[3]  = '{1'b0, 3'b100, 32'h13,  32'h0,        2, 1'b0, 32'h000000A5, 0, -1, 32'h0};
    vt[4]  = '{1'b0, 3'b000, 32'h13,  32'h0,        2, 1'b0, 32'hFFFFFFA5, 0, -1, 32'h0};
    vt[5]  = '{1'b1, 3'b001, 32'h12,  32'hFFFF8001, 3, 1'b0, 32'hFFFFFFA5, 1, 4, 32'h80013344};
    vt[6]  = '{1'b0, 3'b001, 32'h12,  32'h0,        2, 1'b0, 32'hFFFF8001, 0, -1, 32'h0};
    vt[7]  = '{1'b0, 3'b101, 32'h12,  32'h0,        2, 1'b0, 32'h00008001, 0, -1, 32'h0};
    vt[8]  = '{1'b0, 3'b010, 32'h11,  32'h0,        1, 1'b1, 32'h00008001, 0, -1, 32'h0};
    vt[9]  = '{1'b1, 3'b001, 32'h01,  32'h1234,     1, 1'b1, 32'h00008001, 0, 0, 32'h0};
    vt[10] = '{1'b1, 3'b100, 32'h10,  32'h55,       1, 1'b1, 32'h00008001, 0, 4, 32'h80013344};
    vt[11] = '{1'b0, 3'b010, 32'h1000, 32'h0,       1, 1'b1, 32'h00008001, 0, -1, 32'h0};
    vt[12] = '{1'b0, 3'b011, 32'h10,  32'h0,        1, 1'b1, 32'h00008001, 0, -1, 32'h0};
    vt[13] = '{1'b0, 3'b000, 32'h10,  32'h0,        2, 1'b0, 32'h00000044, 0, -1, 32'h0};
    vt[14] = '{1'b0, 3'b001, 32'h10,  32'h0,        2, 1'b0, 32'h00003344, 0, -1, 32'h0};
    vt[15] = '{1'b1, 3'b000, 32'h10,  32'h7F,       3, 1'b0, 32'h00003344, 1, 4, 32'h8001337F};
    vt[16] = '{1'b1, 3'b001, 32'h10,  32'h1234,     3, 1'b0, 32'h00003344, 1, 4, 32'h80011234};
    vt[17] = '{1'b0, 3'b000, 32'h11,  32'h0,        2, 1'b0, 32'h00000012, 0, -1, 32'h0};
    vt[18] = '{1'b0, 3'b010, 32'hFFC, 32'h0,        2, 1'b0, 32'hCAFEF00D, 0, -1, 32'h0};
    vt[19] = '{1'b1, 3'b000, 32'hFFF, 32'h80,       3, 1'b0, 32'hCAFEF00D, 1, 1023, 32'h80FEF00D};
    vt[20] = '{1'b0, 3'b000, 32'hFFF, 32'h0,        2, 1'b0, 32'hFFFFFF80, 0, -1, 32'h0};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    #12;
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset err", {31'b0, err}, 32'h0);
    check("reset wren", {31'b0, wren}, 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset lsu_addr", lsu_addr, 32'h0);
    check("reset wdata", ram_wdata, 32'h0);
    rst_n = 1'b1;

    poke(4, 32'hDEADBEEF);
    poke(1023, 32'hCAFEF00D);
    poke(8, 32'h11111111);
    poke(12, 32'h22222222);
    poke(5, 32'h55555555);

    for (int i = 0; i < 21; i++) do_req($sformatf("vec%0d", i), vt[i]);

    // SB with the request strobe and operands wiggling while busy.
    begin
      int base;
      bit seen;
      @(negedge clk);
      base = wren_cnt;
      req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h20; wdata = 32'hEE;
      @(posedge clk);
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (done) begin
          seen = 1;
          req = 1'b0;
        end else begin
          req = ~req; addr = 32'h30; we = 1'b0; funct3 = 3'b010; wdata = 32'h0;
        end
      end
      req = 1'b0;
      if (!seen) begin
        n_vec++; n_fail++;
        $display("FAIL busy_ignore timeout");
      end
      repeat (3) @(negedge clk);
      check("busy_ignore busy", {31'b0, busy}, 32'h0);
      check("busy_ignore wren_cnt", wren_cnt - base, 1);
      check("busy_ignore mem8", mem[8], 32'h111111EE);
      check("busy_ignore mem12", mem[12], 32'h22222222);
    end

    // Reset pulled during the RD state of an SB.
    begin
      int base;
      @(negedge clk);
      base = wren_cnt;
      req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h14; wdata = 32'h99;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      check("rst_mid in RD lsu_addr", lsu_addr, 32'h5);
      rst_n = 1'b0;
      #1;
      check("rst_mid wren", {31'b0, wren}, 32'h0);
      check("rst_mid busy", {31'b0, busy}, 32'h0);
      check("rst_mid done", {31'b0, done}, 32'h0);
      check("rst_mid rdata", rdata, 32'h0);
      check("rst_mid lsu_addr", lsu_addr, 32'h0);
      check("rst_mid wdata", ram_wdata, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_mid wren_cnt", wren_cnt - base, 0);
      check("rst_mid mem5", mem[5], 32'h55555555);
      check("rst_mid done_lost", {31'b0, done}, 32'h0);
      do_req("post_rst LW", '{1'b0, 3'b010, 32'h14, 32'h0, 2, 1'b0, 32'h55555555, 0, -1, 32'h0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
# lsu_dmem_ctrl

Load/store controller between the single-cycle core's memory stage and the word-wide data RAM. It converts RISC-V byte addresses and access sizes (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-indexed RAM accesses. The RAM has only a full-word write strobe, so SB/SH are done as a multi-cycle read-modify-write. Misaligned, out-of-range and illegal-size requests are reported as errors and never reach the RAM.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the data RAM; word indices >= DEPTH_WORDS are out of range.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  request strobe; sampled only in IDLE.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-aligned.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_done; request was rejected.
- o_rdata  out  32  extended load result; valid with o_done.
- o_lsu_addr  out  32  RAM word index, {2'b00, addr[31:2]}.
- o_wren  out  1  RAM write enable.
- o_wdata  out  32  RAM write data (full word).
- i_data_dmem  in  32  RAM combinational read data for o_lsu_addr.

## Operation
- The FSM has five states: IDLE, RD, WR, DONE, ERR.
- IDLE with i_req=1 latches i_we, i_funct3, i_addr and i_wdata, then validates the request:
  - Error if funct3 is 011/110/111.
  - Error if a store uses 100 or 101.
  - Error if H/HU has addr[0]=1, or W has addr[1:0]!=0.
  - Error if addr[31:2] >= DEPTH_WORDS.
- Next state from IDLE:
  - error -> ERR
  - load -> RD
  - SW -> WR
  - SB/SH -> RD
- RD drives o_lsu_addr and registers i_data_dmem into rd_word. Next state is DONE for a load, WR for SB/SH.
- WR drives o_lsu_addr and o_wdata with o_wren=1. Next state is DONE.
  - SW: o_wdata = wdata.
  - SB: rd_word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: rd_word with half lane addr[1] replaced by wdata[15:0].
  - Little-endian: lane 0 = bits [7:0].
- DONE pulses o_done=1, o_err=0, then returns to IDLE.
- ERR pulses o_done=1, o_err=1, leaves o_rdata unchanged, then returns to IDLE.
- Load extraction, registered into o_rdata on the RD->DONE edge:
  - B: sign-extend the selected byte; BU: zero-extend it.
  - H: sign-extend the selected half; HU: zero-extend it.
  - W: whole word.
- o_rdata holds its value until the next successful load. Stores and errors do not modify it.
- i_req while busy is ignored and not queued. The core holds its request until it sees o_done.
- o_wren is decoded combinationally from state==WR only.
- In IDLE/DONE/ERR: o_lsu_addr=0, o_wdata=0.

## Timing
- Reset (asynchronous): state=IDLE, o_busy=0, o_done=0, o_err=0, o_rdata=0, o_wren=0, o_lsu_addr=0, o_wdata=0.
- Request accepted at edge E. Latency to the o_done cycle:
  - Load: RD during E+1, DONE during E+2 (2 cycles).
  - SW: WR during E+1 (RAM writes at end of E+1), DONE during E+2 (2 cycles).
  - SB/SH: RD E+1, WR E+2, DONE E+3 (3 cycles).
  - Error: ERR during E+1 (1 cycle); no RAM access, o_wren never asserted.
- Back-to-back: a new i_req is accepted in the cycle after DONE/ERR, i.e. in IDLE. Minimum load-to-load spacing is 3 cycles.
- Read-after-write: a load issued after a store's o_done sees the new data, because the write has committed by then.
- Reset asserted mid-operation:
  - Immediate return to IDLE; o_wren drops combinationally.
  - No partial RMW write is committed at any later edge.
  - Pending o_done is lost.
- Input changes while busy have no effect; all operands come from the latched copies.

## Test plan
- LW at 0x10, RAM[4]=0xDEADBEEF -> o_done 2 cycles after accept, o_rdata=0xDEADBEEF, o_err=0.
- SB 0xA5 at 0x13, RAM[4]=0x11223344 -> RD then WR; o_wdata=0xA5223344 with o_wren high exactly 1 cycle; o_done 3 cycles after accept. A following LBU at 0x13 returns 0x000000A5; LB at 0x13 returns 0xFFFFFFA5.
- SH 0x8001 at 0x12 -> RAM[4]=0x80013344. Then LH at 0x12 -> 0xFFFF8001; LHU at 0x12 -> 0x00008001.
- Error cases, each giving o_err=1, o_done 1 cycle after accept, o_wren never high, o_rdata unchanged:
  - LW at 0x11
  - SH at 0x01
  - store with funct3=100
  - address 0x1000 (index 1024) with DEPTH_WORDS=1024
- i_req toggled and i_addr changed during an SB RMW -> ignored; the original address is written.
- i_rst_n pulled low during the RD state of an SB -> o_wren never asserted, RAM word unchanged, all outputs at reset values; the next LW after reset completes normally.
